// File: rtl/csr_hpm_counter_bank.sv
// Machine counter CSR bank: mcycle, minstret, N_HPM event counters, mhpmevent and mcountinhibit.
// Optional HPM_OVERFLOW_IRQ_EN adds a sticky overflow bit 31 per mhpmevent and the ovf_irq output.
module csr_hpm_counter_bank #(
    parameter int N_HPM     = 4,
    parameter int CNT_WIDTH = 64,
    parameter int N_EVENTS  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [11:0]         csr_addr,
    input  logic                csr_wr_en,
    input  logic [1:0]          csr_wr_op,
    input  logic [31:0]         csr_wr_data,
    output logic [31:0]         csr_rd_data,
    output logic                csr_hit,
    input  logic                instret_inc,
    input  logic [N_EVENTS-1:0] events
`ifdef HPM_OVERFLOW_IRQ_EN
    ,
    output logic                ovf_irq
`endif
);

    // Slot 0 = mcycle, slot 1 = minstret, slot k+2 = mhpmcounter(k+3).
    localparam int N_CNT      = N_HPM + 2;
    localparam int N_EVT_SLOT = (N_HPM > 0) ? N_HPM : 1;
    localparam int INH_W      = N_HPM + 3;
    localparam logic [5:0]           HPM_END  = 6'(N_HPM + 3);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [INH_W-1:0]     INH_MASK = {{(INH_W-2){1'b1}}, 2'b01};

    function automatic logic [31:0] csr_op(input logic [1:0] op, input logic [31:0] old_val,
                                           input logic [31:0] wdata);
        case (op)
            2'd0:    return wdata;
            2'd1:    return old_val | wdata;
            2'd2:    return old_val & ~wdata;
            default: return old_val;
        endcase
    endfunction

    function automatic logic [31:0] half_sel(input logic [CNT_WIDTH-1:0] v, input logic hi);
        logic [63:0] f;
        f = 64'd0;
        f[CNT_WIDTH-1:0] = v;
        return hi ? f[63:32] : f[31:0];
    endfunction

    logic [CNT_WIDTH-1:0] cnt_q [N_CNT];
    logic [CNT_WIDTH-1:0] cnt_d [N_CNT];
    logic [N_EVENTS-1:0]  evt_q [N_EVT_SLOT];
    logic [N_EVENTS-1:0]  evt_d [N_EVT_SLOT];
    logic [INH_W-1:0]     inh_q, inh_d;
`ifdef HPM_OVERFLOW_IRQ_EN
    logic [N_EVT_SLOT-1:0] of_q, of_d;
`endif

    logic [4:0]       idx_s, slot_s;
    logic             slot_ok_s, grp_lo_s, grp_hi_s, grp_cfg_s, wr_s;
    logic [31:0]      cnt_rd_s, evt_rd_s, inh_rd_s, new_s;
    logic [N_CNT-1:0] inc_s, wr_cnt_s;

    assign idx_s     = csr_addr[4:0];
    assign grp_lo_s  = (csr_addr[11:5] == 7'h58);
    assign grp_hi_s  = (csr_addr[11:5] == 7'h5C);
    assign grp_cfg_s = (csr_addr[11:5] == 7'h19);

    // Map CSR counter index onto an implemented slot
    always_comb begin
        slot_s    = 5'd0;
        slot_ok_s = 1'b0;
        if (idx_s == 5'd0) begin
            slot_ok_s = 1'b1;
        end else if (idx_s == 5'd2) begin
            slot_s    = 5'd1;
            slot_ok_s = 1'b1;
        end else if (({1'b0, idx_s} >= 6'd3) && ({1'b0, idx_s} < HPM_END)) begin
            slot_s    = idx_s - 5'd1;
            slot_ok_s = 1'b1;
        end else begin
            slot_ok_s = 1'b0;
        end
    end

    // Read-side selection of counter halves, events and inhibit
    always_comb begin
        logic [31:0] evt_val;
        evt_val  = 32'd0;
        cnt_rd_s = 32'd0;
        evt_rd_s = 32'd0;
        inh_rd_s = 32'd0;
        inh_rd_s[INH_W-1:0] = inh_q;
        for (int s = 0; s < N_CNT; s++) begin
            cnt_rd_s = cnt_rd_s | ({32{slot_ok_s && (slot_s == 5'(s))}} & half_sel(cnt_q[s], grp_hi_s));
        end
        for (int k = 0; k < N_HPM; k++) begin
            evt_val = 32'd0;
            evt_val[N_EVENTS-1:0] = evt_q[k];
`ifdef HPM_OVERFLOW_IRQ_EN
            evt_val[31] = of_q[k];
`endif
            evt_rd_s = evt_rd_s | ({32{idx_s == 5'(k + 3)}} & evt_val);
        end
    end

    // Address hit and read mux
    always_comb begin
        csr_hit     = 1'b0;
        csr_rd_data = 32'd0;
        if (grp_lo_s || grp_hi_s) begin
            csr_hit     = (idx_s != 5'd1);
            csr_rd_data = cnt_rd_s;
        end else if (grp_cfg_s) begin
            csr_hit     = (idx_s != 5'd1) && (idx_s != 5'd2);
            csr_rd_data = (idx_s == 5'd0) ? inh_rd_s : evt_rd_s;
        end else begin
            csr_hit     = 1'b0;
            csr_rd_data = 32'd0;
        end
    end

    assign wr_s  = csr_wr_en && (csr_wr_op != 2'd3) && csr_hit;
    assign new_s = csr_op(csr_wr_op, csr_rd_data, csr_wr_data);

    // Per-counter increment enables, using the inhibit value held this cycle
    always_comb begin
        inc_s    = {N_CNT{1'b0}};
        inc_s[0] = ~inh_q[0];
        inc_s[1] = instret_inc & ~inh_q[2];
        for (int k = 0; k < N_HPM; k++) begin
            inc_s[k+2] = ~inh_q[k+3] & (|(events & evt_q[k]));
        end
    end

    // Which counter slot takes a software write this cycle
    always_comb begin
        wr_cnt_s = {N_CNT{1'b0}};
        for (int s = 0; s < N_CNT; s++) begin
            wr_cnt_s[s] = wr_s && (grp_lo_s || grp_hi_s) && slot_ok_s && (slot_s == 5'(s));
        end
    end

    // Counter next state: a write to either half wins over the increment
    always_comb begin
        for (int s = 0; s < N_CNT; s++) begin
            cnt_d[s] = cnt_q[s];
            if (wr_cnt_s[s]) begin
                if (grp_hi_s) begin
                    cnt_d[s][CNT_WIDTH-1:32] = new_s[CNT_WIDTH-33:0];
                end else begin
                    cnt_d[s][31:0] = new_s;
                end
            end else if (inc_s[s]) begin
                cnt_d[s] = cnt_q[s] + CNT_ONE;
            end else begin
                cnt_d[s] = cnt_q[s];
            end
        end
    end

    // Inhibit and event-selector next state
    always_comb begin
        inh_d = inh_q;
        if (wr_s && grp_cfg_s && (idx_s == 5'd0)) begin
            inh_d = new_s[INH_W-1:0] & INH_MASK;
        end else begin
            inh_d = inh_q;
        end
        for (int k = 0; k < N_EVT_SLOT; k++) begin
            evt_d[k] = evt_q[k];
        end
        for (int k = 0; k < N_HPM; k++) begin
            if (wr_s && grp_cfg_s && (idx_s == 5'(k + 3))) begin
                evt_d[k] = new_s[N_EVENTS-1:0];
            end else begin
                evt_d[k] = evt_q[k];
            end
        end
    end

`ifdef HPM_OVERFLOW_IRQ_EN
    // Sticky overflow: set only by an increment wrapping to zero; a wrap beats a same-cycle clear
    always_comb begin
        logic wrap;
        wrap = 1'b0;
        of_d = of_q;
        for (int k = 0; k < N_HPM; k++) begin
            wrap = inc_s[k+2] && !wr_cnt_s[k+2] && (cnt_q[k+2] == CNT_MAX);
            if (wr_s && grp_cfg_s && (idx_s == 5'(k + 3))) begin
                of_d[k] = new_s[31] | wrap;
            end else begin
                of_d[k] = of_q[k] | wrap;
            end
        end
    end

    assign ovf_irq = |of_q;
`endif

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < N_CNT; s++) begin
                cnt_q[s] <= {CNT_WIDTH{1'b0}};
            end
            for (int k = 0; k < N_EVT_SLOT; k++) begin
                evt_q[k] <= {N_EVENTS{1'b0}};
            end
            inh_q <= {INH_W{1'b0}};
`ifdef HPM_OVERFLOW_IRQ_EN
            of_q  <= {N_EVT_SLOT{1'b0}};
`endif
        end else begin
            for (int s = 0; s < N_CNT; s++) begin
                cnt_q[s] <= cnt_d[s];
            end
            for (int k = 0; k < N_EVT_SLOT; k++) begin
                evt_q[k] <= evt_d[k];
            end
            inh_q <= inh_d;
`ifdef HPM_OVERFLOW_IRQ_EN
            of_q  <= of_d;
`endif
        end
    end

endmodule

// File: doc/csr_hpm_counter_bank.md
Name: csr_hpm_counter_bank

Overview:
- Parametrised machine counter/event-counter CSR bank for the RV32 core: mcycle, minstret, N_HPM programmable mhpmcounterN with matching mhpmeventN, plus mcountinhibit.
- Sits beside the CSR unit; decodes the standard counter CSR addresses and applies CSR_RW/CSR_RS/CSR_RC write ops.
- Generalises fixed mcycle/minstret counting to configurable counter width, count and event-source set.

Parameters:
- N_HPM, 4, number of implemented mhpmcounters starting at index 3 (0..29); counters 3+N_HPM..31 are hardwired zero.
- CNT_WIDTH, 64, implemented bits per counter (33..64); bits above read 0, writes to them ignored.
- N_EVENTS, 8, width of the event input vector; writable low bits of each mhpmeventN.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous active-high reset
- csr_addr  in  12  CSR address, valid with csr_rd_en/csr_wr_en
- csr_wr_en  in  1  apply write this cycle
- csr_wr_op  in  2  CSR_RW=0, CSR_RS=1, CSR_RC=2; value 3 = no write
- csr_wr_data  in  32  write operand
- csr_rd_data  out  32  combinational read of addressed CSR (pre-update value)
- csr_hit  out  1  addr belongs to this bank
- instret_inc  in  1  one instruction retired this cycle
- events  in  N_EVENTS  per-cycle event pulses

Behaviour:
- Reset: all counters, mhpmevent and mcountinhibit = 0. No registered outputs; csr_rd_data = 0 and csr_hit = 0 when nothing is addressed.
- Address map (csr_hit=1):
  - 0xB00 mcycle lo, 0xB80 mcycle hi; 0xB02/0xB82 minstret.
  - 0xB03..0xB1F / 0xB83..0xB9F mhpmcounter3..31 lo/hi.
  - 0x320 mcountinhibit; 0x323..0x33F mhpmevent3..31.
  - 0xB01/0xB81 and all other addresses: csr_hit=0, rd 0.
- Write value:
  - RW: new = wdata.
  - RS: new = old | wdata.
  - RC: new = old & ~wdata.
  - Unimplemented bits are masked after the op.
- mcountinhibit:
  - Bit 0 = CY, bit 2 = IR, bits 3..2+N_HPM writable.
  - Bit 1 and bits above 2+N_HPM are hardwired 0.
- mhpmeventN: bits N_EVENTS-1:0 writable, rest read 0.
- Counting, each cycle, per counter with inhibit bit clear:
  - mcycle += 1.
  - minstret += instret_inc.
  - mhpmcounterN += 1 if (events & mhpmeventN[N_EVENTS-1:0]) != 0. Multiple matching events in one cycle still add exactly 1.
  - Event = 0 never counts.
- Wrap: counter at 2^CNT_WIDTH-1 increments to 0. No saturation.
- Write vs increment, same cycle:
  - A CSR write to either half of a counter suppresses that counter's increment for the cycle.
  - Written half takes the new value; other half is unchanged (no carry from the written lo half).
  - Next-cycle read returns exactly the written value.
- Write to mcountinhibit: takes effect from the next cycle; the current cycle still counts with the old inhibit.
- Hi half with CNT_WIDTH<64: bits [CNT_WIDTH-33:0] implemented, rest 0.
- Read of hardwired-zero counters/events returns 0; writes are silently dropped; csr_hit=1.
- Reset asserted mid-count: all state cleared on that edge; no increment occurs on that edge.

Optional Feature:
- Macro HPM_OVERFLOW_IRQ_EN.
- When defined:
  - Each mhpmeventN gains sticky bit 31 (OF), set when that counter wraps to 0 by increment (not by write).
  - OF is writable by software (RW/RS/RC apply).
  - New output port ovf_irq (1 bit) = OR of all OF bits, combinational from registers; reset 0.
- When undefined: bit 31 reads 0, writes ignored, no ovf_irq port.

Test Plan:
- Reset, then idle 10 cycles, mcountinhibit=0: read 0xB00 -> 10 (±fixed read offset, checked exactly by model); 0xB02 -> 0; 0xB80 -> 0.
- RW 0xB00=0xFFFFFFFF, RW 0xB80=0: after 2 cycles lo=0x00000001, hi=0x00000001 (carry across halves).
- RW 0x323=0x05, events=0x04 for 3 cycles, then 0x05 for 2 cycles, then 0x02 for 4 cycles: mhpmcounter3 = 5.
- RS 0x320 with 0x00000004, pulse instret_inc 6 cycles -> minstret unchanged. Then RC 0x320 with 0x4, 6 pulses -> minstret +6. Write 0x320=0xFFFFFFFF with N_HPM=4 -> reads 0x0000007D.
- Write 0xB03=0x100 on the same cycle an enabled event fires -> next read 0x100. N_HPM=4: RW 0xB10=0x55 -> reads 0, csr_hit=1. Read 0xB01 -> csr_hit=0.
- HPM_OVERFLOW_IRQ_EN, CNT_WIDTH=40: set mhpmcounter3 to 0xFF_FFFFFFFF, event enabled, one event -> counter 0, OF=1, ovf_irq=1. RC 0x323 with 0x80000000 -> ovf_irq=0 next cycle.
